fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Parametrised next-generation fetch stage. Owns the fetch PC, issues in-order requests to an
//  instruction memory over a valid/ready request + valid response interface, and buffers
//  returned instructions in a FQ_DEPTH-entry queue ahead of decode. Supports redirect
//  (jump/branch/flush) with discard of in-flight responses. Sits between the PC/redirect
//  logic and the decode stage.
// PARAMETERS
//  XLEN      32    PC/address width
//  ILEN      32    instruction width
//  RESET_PC  0     fetch PC after reset; bits [1:0] must be 0
//  FQ_DEPTH  4     queue entries; power of 2, >=2; also the outstanding-request bound
// PORTS
//  clk             in   1     single clock, rising edge
//  rst             in   1     synchronous, active-high reset
//  redirect_valid  in   1     load new fetch PC this cycle, flush queue
//  redirect_pc     in   XLEN  target PC; bits [1:0] ignored (forced 0)
//  imem_req_valid  out  1     request to instruction memory
//  imem_req_ready  in   1     memory accepts request
//  imem_req_addr   out  XLEN  request address (= fetch PC)
//  imem_rsp_valid  in   1     response; in-order, 1 per accepted request, any latency >=1
//  imem_rsp_data   in   ILEN  returned instruction
//  if_valid        out  1     head instruction available to decode
//  if_ready        in   1     decode accepts head
//  if_instr        out  ILEN  head instruction
//  if_pc           out  XLEN  PC of head instruction
// BEHAVIOUR
//  - Reset (sync, wins over all inputs): fetch_pc=RESET_PC; alloc/fill/read ptrs=0; drop_cnt=0;
//    if_valid=0, imem_req_valid=0 during rst. Reset mid-traffic: responses arriving after reset
//    are NOT discarded, so memory must be reset together with this block.
//  - Queue entry: {pc, instr, filled}. Allocated at request handshake (pc stored, filled=0);
//    filled in order by next non-dropped response; popped at if_valid&if_ready.
//  - imem_req_valid = !rst & !redirect_valid & (used + drop_cnt < FQ_DEPTH), used = allocated,
//    unpopped entries. imem_req_addr = fetch_pc. Handshake: fetch_pc += 4 (wraps mod 2^XLEN).
//  - if_valid = head entry allocated & filled; if_instr/if_pc from head (combinational from
//    regs). Min latency req handshake -> if_valid = mem latency + 1 cycle (response registered).
//  - Response: if drop_cnt>0, discard and drop_cnt-=1; else write fill ptr entry, fill ptr+=1.
//  - Full: used==FQ_DEPTH (or used+drop_cnt==FQ_DEPTH) -> no request; response still accepted
//    (space guaranteed by credit rule). Empty: if_valid=0. Same-cycle pop+alloc+fill all legal.
//  - Redirect cycle: a pop handshake in that cycle completes normally (decode sees it); then
//    all ptrs clear, fetch_pc={redirect_pc[XLEN-1:2],2'b00}, drop_cnt := drop_cnt + unfilled
//    entries, minus 1 if imem_rsp_valid this cycle (that response is discarded). No request
//    issued in the redirect cycle; requests resume next cycle even while drop_cnt>0.
//  - Back-to-back redirects: last one wins; drop_cnt accumulates per rule above.
//  - Invariant: used + drop_cnt <= FQ_DEPTH; drop_cnt width clog2(FQ_DEPTH)+1.
// STRUCTURE
//  - cpu_pkg: XLEN/ILEN defaults, RESET_PC default, PC_STEP=4, fetch entry struct {pc,instr}.
//  - Sub-module fetch_queue: ring buffer with alloc/fill/read pointers (clog2(FQ_DEPTH)+1 bits
//    for full/empty), clear input. fetch_unit holds fetch_pc, drop_cnt, credit logic.
// TESTING
//  1 Reset, mem latency 1, if_ready=1: addrs 0,4,8,... issued 1/cycle; first if_valid 2 cycles
//    after first handshake with if_pc=0; if_instr matches mem image in order.
//  2 if_ready=0, FQ_DEPTH=4: exactly 4 requests issued, then imem_req_valid=0; raise if_ready ->
//    pops PCs 0,4,8,12 in order, requests resume at 16.
//  3 Latency 3, redirect to 0x103 with 3 requests in flight: next request addr=0x100; 3 stale
//    responses dropped; first if_pc=0x100; no stale instruction ever visible.
//  4 Redirect same cycle as response and pop: popped instr delivered once, response discarded,
//    drop_cnt accounting correct (checked by assertion used+drop_cnt<=FQ_DEPTH).
//  5 imem_req_ready random 50%, if_ready random: scoreboard if_pc sequence strictly +4 between
//    redirects, fetch_pc wrap 0xFFFFFFFC -> 0x0.
//  6 rst asserted mid-stream with entries queued: next cycle if_valid=0, next addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants and types for the fetch stage
//
// Purpose : default widths, reset PC and PC increment used by fetch_unit and
//           its queue, plus the default-width view of one queue entry.
// Ports   : none (package).
package fetch_unit_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int ILEN_DEFAULT = 32;
   localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;
   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [XLEN_DEFAULT-1:0] pc;
      logic [ILEN_DEFAULT-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// rtl/fetch_unit_queue.sv - in-order fetch queue with alloc/fill/read pointers
//
// Purpose : ring buffer of {pc, instr}. An entry is allocated when its request
//           is accepted, filled in order by responses and popped by decode.
// Ports   : clk, rst        clock, synchronous active-high reset
//           clear           drop every entry (redirect)
//           alloc, alloc_pc allocate tail entry with its PC
//           fill, fill_instr write the oldest unfilled entry
//           pop             remove head entry
//           head_valid      head entry allocated and filled
//           head_pc/instr   head entry contents
//           used            allocated, unpopped entries
//           unfilled        allocated entries still waiting for a response
module fetch_unit_queue
   import fetch_unit_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int ILEN  = ILEN_DEFAULT,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       alloc,
   input  logic [XLEN-1:0]            alloc_pc,
   input  logic                       fill,
   input  logic [ILEN-1:0]            fill_instr,
   input  logic                       pop,
   output logic                       head_valid,
   output logic [XLEN-1:0]            head_pc,
   output logic [ILEN-1:0]            head_instr,
   output logic [$clog2(DEPTH):0]     used,
   output logic [$clog2(DEPTH):0]     unfilled
);

   localparam int PW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty.
   logic [PW:0]     alloc_ptr;
   logic [PW:0]     fill_ptr;
   logic [PW:0]     rd_ptr;
   logic [XLEN-1:0] pc_q    [DEPTH];
   logic [ILEN-1:0] instr_q [DEPTH];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         alloc_ptr <= '0;
         fill_ptr  <= '0;
         rd_ptr    <= '0;
      end else begin
         if (alloc) alloc_ptr <= alloc_ptr + 1'b1;
         if (fill)  fill_ptr  <= fill_ptr + 1'b1;
         if (pop)   rd_ptr    <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (alloc) pc_q[alloc_ptr[PW-1:0]] <= alloc_pc;
      if (fill)  instr_q[fill_ptr[PW-1:0]] <= fill_instr;
   end

   // Fills arrive strictly in allocation order, so the head is filled exactly
   // when the fill pointer has moved past it; no per-entry flag is needed.
   assign head_valid = (rd_ptr != fill_ptr);
   assign head_pc    = pc_q[rd_ptr[PW-1:0]];
   assign head_instr = instr_q[rd_ptr[PW-1:0]];
   assign used       = alloc_ptr - rd_ptr;
   assign unfilled   = alloc_ptr - fill_ptr;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch stage: fetch PC, request credit, redirect handling
//
// Purpose : issues in-order instruction fetches, buffers responses in a
//           FQ_DEPTH-entry queue ahead of decode, and on redirect flushes the
//           queue and discards responses still in flight.
// Ports   : clk, rst                   clock, synchronous active-high reset
//           redirect_valid/pc          load new fetch PC and flush
//           imem_req_valid/ready/addr  request channel to instruction memory
//           imem_rsp_valid/data        in-order responses, one per request
//           if_valid/ready/instr/pc    head instruction to decode
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEFAULT,
   parameter int              ILEN     = ILEN_DEFAULT,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
   parameter int              FQ_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [ILEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   used;
   logic [CW-1:0]   unfilled;
   logic [CW:0]     credit_sum;
   logic [CW-1:0]   redirect_drop;
   logic            head_valid;
   logic            req_fire;
   logic            pop;
   logic            fill;

   // Entries in the queue plus responses still owed to discarded requests
   // bound the outstanding requests, so every response has a slot.
   assign credit_sum     = {1'b0, used} + {1'b0, drop_cnt};
   assign imem_req_valid = !rst && !redirect_valid && (credit_sum < (CW+1)'(FQ_DEPTH));
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign if_valid = !rst && head_valid;
   assign pop      = if_valid && if_ready;
   assign fill     = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

   // A response arriving in the redirect cycle retires either one pending
   // drop or one unfilled entry; either way it is discarded now, hence -1.
   // The sum never exceeds FQ_DEPTH, so CW bits of modular math are exact.
   assign redirect_drop = drop_cnt + unfilled - CW'(imem_rsp_valid);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         drop_cnt <= '0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_pc & ~XLEN'(3);
         drop_cnt <= redirect_drop;
      end else begin
         if (req_fire) fetch_pc <= fetch_pc + XLEN'(PC_STEP);
         if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
   end

   fetch_unit_queue #(
      .XLEN  (XLEN),
      .ILEN  (ILEN),
      .DEPTH (FQ_DEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .clear      (redirect_valid),
      .alloc      (req_fire),
      .alloc_pc   (fetch_pc),
      .fill       (fill),
      .fill_instr (imem_rsp_data),
      .pop        (pop),
      .head_valid (head_valid),
      .head_pc    (if_pc),
      .head_instr (if_instr),
      .used       (used),
      .unfilled   (unfilled)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   always #5 clk = ~clk;

   fetch_unit #(
      .XLEN     (32),
      .ILEN     (32),
      .RESET_PC (32'h0),
      .FQ_DEPTH (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } pend_t;

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] redir_pc;
      logic        req_ready;
      logic        if_rdy;
      logic        e_req_valid;
      logic [31:0] e_req_addr;
      logic        e_if_valid;
      logic [31:0] e_if_pc;
   } vec_t;

   pend_t       pend[$];
   vec_t        vecs[9];
   int          cycle = 0;
   int          latency = 1;
   int          vec_cnt = 0;
   int          err_cnt = 0;
   int          hs_cnt = 0;
   int          pop_cnt = 0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] last_hs_addr;
   logic [31:0] last_pop_pc;
   logic        obs_req_valid;
   logic [31:0] obs_req_addr;
   logic        obs_if_valid;
   logic [31:0] obs_if_pc;
   logic        saw_top = 1'b0;
   logic        saw_wrap = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Called at negedge with inputs already driven: plays memory, observes
   // outputs, scores pops, then advances one clock to the next negedge.
   task automatic step();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (pend.size() > 0 && pend[0].due <= cycle) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(pend[0].addr);
      end
      #1;
      obs_req_valid = imem_req_valid;
      obs_req_addr  = imem_req_addr;
      obs_if_valid  = if_valid;
      obs_if_pc     = if_pc;
      if (imem_rsp_valid) void'(pend.pop_front());
      if (rst) begin
         pend.delete();
      end else if (imem_req_valid && imem_req_ready) begin
         pend.push_back('{imem_req_addr, cycle + latency});
         hs_cnt++;
         last_hs_addr = imem_req_addr;
      end
      if (if_valid && if_ready) begin
         check("if_pc", 64'(if_pc), 64'(exp_pc));
         check("if_instr", 64'(if_instr), 64'(mem_word(exp_pc)));
         if (exp_pc == 32'hFFFF_FFFC) saw_top = 1'b1;
         if (saw_top && if_pc == 32'h0) saw_wrap = 1'b1;
         last_pop_pc = if_pc;
         pop_cnt++;
         exp_pc = exp_pc + 32'd4;
      end
      if (rst) exp_pc = 32'h0;
      else if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
      if (!rst) check("credit", 64'((dut.used + dut.drop_cnt) <= 3'd4), 64'(1));
      @(posedge clk);
      cycle++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; if_ready = 1'b0;
      step();
      check("rst_req_valid", 64'(obs_req_valid), 64'(0));
      check("rst_if_valid", 64'(obs_if_valid), 64'(0));
      rst = 1'b0;
   endtask

   initial begin
      int hs_before;
      int pops_before;
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
      imem_req_ready = 1'b0; if_ready = 1'b0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      @(negedge clk);

      // Latency 1, decode always ready; redirect lands with a pop and a response.
      vecs[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0};
      vecs[1] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,   1'b0, 32'h0};
      vecs[2] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h4,   1'b0, 32'h0};
      vecs[3] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8,   1'b1, 32'h0};
      vecs[4] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'hC,   1'b1, 32'h4};
      vecs[5] = '{1'b0, 1'b1, 32'h103, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8};
      vecs[6] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0};
      vecs[7] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h104, 1'b0, 32'h0};
      vecs[8] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h108, 1'b1, 32'h100};
      latency = 1;
      for (int v = 0; v < 9; v++) begin
         rst            = vecs[v].rst;
         redirect_valid = vecs[v].redir;
         redirect_pc    = vecs[v].redir_pc;
         imem_req_ready = vecs[v].req_ready;
         if_ready       = vecs[v].if_rdy;
         step();
         check($sformatf("v%0d_req_valid", v), 64'(obs_req_valid), 64'(vecs[v].e_req_valid));
         if (vecs[v].e_req_valid)
            check($sformatf("v%0d_req_addr", v), 64'(obs_req_addr), 64'(vecs[v].e_req_addr));
         check($sformatf("v%0d_if_valid", v), 64'(obs_if_valid), 64'(vecs[v].e_if_valid));
         if (vecs[v].e_if_valid)
            check($sformatf("v%0d_if_pc", v), 64'(obs_if_pc), 64'(vecs[v].e_if_pc));
      end
      redirect_valid = 1'b0;
      check("t1_drop_cnt", 64'(dut.drop_cnt), 64'(0));

      // Decode stalled: exactly FQ_DEPTH requests, then resume at 16.
      latency = 1;
      do_reset();
      hs_before = hs_cnt;
      imem_req_ready = 1'b1; if_ready = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("t2_hs_count", 64'(hs_cnt - hs_before), 64'(4));
      check("t2_req_stalled", 64'(obs_req_valid), 64'(0));
      check("t2_if_valid", 64'(obs_if_valid), 64'(1));
      pops_before = pop_cnt;
      hs_before = hs_cnt;
      if_ready = 1'b1;
      for (int i = 0; i < 20 && hs_cnt == hs_before; i++) step();
      check("t2_resume_addr", 64'(last_hs_addr), 64'(32'h10));
      for (int i = 0; i < 6; i++) step();
      check("t2_pops", 64'(pop_cnt - pops_before >= 4), 64'(1));

      // Latency 3, redirect with three requests in flight.
      latency = 3;
      do_reset();
      imem_req_ready = 1'b1; if_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      step();
      check("t3_redir_req_valid", 64'(obs_req_valid), 64'(0));
      check("t3_drop_cnt", 64'(dut.drop_cnt), 64'(2));
      redirect_valid = 1'b0;
      pops_before = pop_cnt;
      step();
      check("t3_next_addr", 64'(last_hs_addr), 64'(32'h100));
      for (int i = 0; i < 20 && pop_cnt == pops_before; i++) step();
      check("t3_first_pc", 64'(last_pop_pc), 64'(32'h100));
      for (int i = 0; i < 10; i++) step();
      check("t3_drop_drained", 64'(dut.drop_cnt), 64'(0));

      // Random handshakes, wrap through 0xFFFFFFFC, occasional redirects.
      latency = 2;
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF0;
      imem_req_ready = 1'b1; if_ready = 1'b1;
      step();
      pops_before = pop_cnt;
      for (int i = 0; i < 600; i++) begin
         redirect_valid = (i > 200) && ($urandom_range(0, 31) == 0);
         redirect_pc    = $urandom;
         imem_req_ready = 1'($urandom_range(0, 1));
         if_ready       = 1'($urandom_range(0, 1));
         step();
      end
      redirect_valid = 1'b0;
      check("t5_wrap_seen", 64'(saw_wrap), 64'(1));
      check("t5_traffic", 64'(pop_cnt - pops_before > 50), 64'(1));

      // Reset mid-stream with entries queued.
      imem_req_ready = 1'b1; if_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check("t6_queued", 64'(obs_if_valid), 64'(1));
      rst = 1'b1;
      step();
      check("t6_rst_if_valid", 64'(obs_if_valid), 64'(0));
      check("t6_rst_req_valid", 64'(obs_req_valid), 64'(0));
      rst = 1'b0;
      step();
      check("t6_if_valid", 64'(obs_if_valid), 64'(0));
      check("t6_req_valid", 64'(obs_req_valid), 64'(1));
      check("t6_req_addr", 64'(obs_req_addr), 64'(32'h0));
      if_ready = 1'b1;
      for (int i = 0; i < 10; i++) step();

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
